// File: rtl/spm_fetch_arbiter.sv
// Round-robin fetch arbiter sharing one sparse-matrix read port among NUM_CH channels.
// Tracks fixed-latency returns so each channel sees data only on its own return cycle.
module spm_fetch_arbiter #(
    parameter int DATA_W  = 32,
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spmv_init,
    input  logic                     start,
    input  logic [NUM_CH*ADDR_W-1:0] ch_base_addr,
    input  logic [NUM_CH*ADDR_W-1:0] ch_nnz,
    input  logic [NUM_CH-1:0]        ch_hold,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic [3*DATA_W-1:0]      mem_rd_data,
    output logic [DATA_W-1:0]        spm_val,
    output logic [DATA_W-1:0]        spm_col_idx,
    output logic [DATA_W-1:0]        spm_row_len,
    output logic [NUM_CH-1:0]        spm_fetch_stall,
    output logic [NUM_CH-1:0]        spm_fetch_done,
    output logic                     busy,
    output logic                     all_done
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OUT_W = $clog2(MEM_LAT + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr   [NUM_CH];
    logic [ADDR_W-1:0]   rem   [NUM_CH];
    logic [OUT_W-1:0]    outst [NUM_CH];
    logic [CH_W-1:0]     rr_last;
    logic [MEM_LAT-1:0]  tag_v;
    logic [CH_W-1:0]     tag_ch [MEM_LAT];

    logic                any_rem;
    logic [NUM_CH-1:0]   eligible;
    logic                issue;
    logic [CH_W-1:0]     grant;
    logic                ret_v;
    logic [CH_W-1:0]     ret_ch;
    logic                pipe_empty;

    assign ret_v  = tag_v[MEM_LAT-1];
    assign ret_ch = tag_ch[MEM_LAT-1];

    // Search downward so the channel nearest rr_last+1 is the last (winning) assignment.
    always_comb begin : arb
        logic [CH_W-1:0] idx;
        logic            found;
        idx      = '0;
        found    = 1'b0;
        grant    = '0;
        any_rem  = 1'b0;
        eligible = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (rem[c] != '0) any_rem = 1'b1;
            eligible[c] = (rem[c] != '0) && !ch_hold[c];
        end
        for (int unsigned k = NUM_CH; k >= 1; k--) begin
            idx = CH_W'((32'(rr_last) + k) % NUM_CH);
            if (eligible[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
        issue       = (state == RUN) && found;
        mem_rd_en   = issue;
        mem_rd_addr = issue ? ptr[grant] : '0;
    end

    // The tag in the last stage returns this cycle, so only upstream stages hold DRAIN.
    always_comb begin
        pipe_empty = 1'b1;
        for (int unsigned s = 0; s + 1 < MEM_LAT; s++) begin
            if (tag_v[s]) pipe_empty = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (!any_rem) state_nxt = DRAIN;
            DRAIN:   if (pipe_empty) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (spmv_init) state_nxt = IDLE;
    end

    always_comb begin
        spm_fetch_stall = '1;
        spm_val         = '0;
        spm_col_idx     = '0;
        spm_row_len     = '0;
        if (ret_v) begin
            spm_fetch_stall[ret_ch] = 1'b0;
            spm_val                 = mem_rd_data[DATA_W-1:0];
            spm_col_idx             = mem_rd_data[2*DATA_W-1:DATA_W];
            spm_row_len             = mem_rd_data[3*DATA_W-1:2*DATA_W];
        end
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            spm_fetch_done[c] = (state != IDLE) && (rem[c] == '0) && (outst[c] == '0);
        end
        busy     = (state == RUN) || (state == DRAIN);
        all_done = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rr_last <= CH_W'(NUM_CH - 1);
            tag_v   <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                ptr[c]   <= '0;
                rem[c]   <= '0;
                outst[c] <= '0;
            end
            for (int unsigned s = 0; s < MEM_LAT; s++) tag_ch[s] <= '0;
        end else if (spmv_init) begin
            state   <= IDLE;
            rr_last <= CH_W'(NUM_CH - 1);
            tag_v   <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                ptr[c]   <= '0;
                rem[c]   <= '0;
                outst[c] <= '0;
            end
            for (int unsigned s = 0; s < MEM_LAT; s++) tag_ch[s] <= '0;
        end else begin
            state     <= state_nxt;
            tag_v[0]  <= issue;
            tag_ch[0] <= grant;
            for (int unsigned s = 1; s < MEM_LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_ch[s] <= tag_ch[s-1];
            end
            if (((state == IDLE) || (state == DONE)) && start) begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    ptr[c] <= ch_base_addr[c*ADDR_W +: ADDR_W];
                    rem[c] <= ch_nnz[c*ADDR_W +: ADDR_W];
                end
            end
            if (issue) begin
                ptr[grant] <= ptr[grant] + ADDR_W'(1);
                rem[grant] <= rem[grant] - ADDR_W'(1);
                rr_last    <= grant;
            end
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if ((issue && (grant == CH_W'(c))) && !(ret_v && (ret_ch == CH_W'(c))))
                    outst[c] <= outst[c] + OUT_W'(1);
                else if (!(issue && (grant == CH_W'(c))) && (ret_v && (ret_ch == CH_W'(c))))
                    outst[c] <= outst[c] - OUT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spm_fetch_arbiter.sv
// Self-checking bench for spm_fetch_arbiter: directed scenarios plus randomized passes
// compared each cycle against a queue-based reference model.
module tb_spm_fetch_arbiter;

    localparam int DW = 32;
    localparam int NC = 4;
    localparam int AW = 16;
    localparam int ML = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             spmv_init = 1'b0;
    logic             start = 1'b0;
    logic [NC*AW-1:0] ch_base_addr = '0;
    logic [NC*AW-1:0] ch_nnz = '0;
    logic [NC-1:0]    ch_hold = '0;
    logic             mem_rd_en;
    logic [AW-1:0]    mem_rd_addr;
    logic [3*DW-1:0]  mem_rd_data = '0;
    logic [DW-1:0]    spm_val, spm_col_idx, spm_row_len;
    logic [NC-1:0]    spm_fetch_stall, spm_fetch_done;
    logic             busy, all_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spm_fetch_arbiter #(.DATA_W(DW), .NUM_CH(NC), .ADDR_W(AW), .MEM_LAT(ML)) dut (
        .clk(clk), .reset(reset), .spmv_init(spmv_init), .start(start),
        .ch_base_addr(ch_base_addr), .ch_nnz(ch_nnz), .ch_hold(ch_hold),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .spm_val(spm_val), .spm_col_idx(spm_col_idx), .spm_row_len(spm_row_len),
        .spm_fetch_stall(spm_fetch_stall), .spm_fetch_done(spm_fetch_done),
        .busy(busy), .all_done(all_done)
    );

    // Reference model: pass state, per-channel pointer/remaining, and a queue of reads in flight.
    typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mstate_t;
    typedef struct {
        int unsigned   due;
        int unsigned   ch;
        logic [AW-1:0] addr;
    } flight_t;

    mstate_t         m_state;
    int unsigned     m_rem [NC];
    logic [AW-1:0]   m_ptr [NC];
    int unsigned     m_rr;
    int unsigned     cyc = 0;
    flight_t         fl[$];
    logic            use_fixed = 1'b0;
    logic [3*DW-1:0] fixed_word = '0;
    logic [AW-1:0]   iss_log[$];
    int unsigned     iss_cyc[$];
    logic [NC+3*DW-1:0] ret_log[$];

    logic [AW-1:0] exp_t1 [6] = '{16'h10, 16'h20, 16'h40, 16'h11, 16'h41, 16'h42};
    logic [AW-1:0] exp_t2 [8] = '{16'h100, 16'h300, 16'h400, 16'h101, 16'h301, 16'h401, 16'h200, 16'h201};

    function automatic logic [3*DW-1:0] mem_word(input logic [AW-1:0] a);
        return {32'(a) ^ 32'h5A5A0000, 32'(a) + 32'h1000, {16'hC0DE, a}};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_rr    = NC - 1;
        fl.delete();
        for (int unsigned c = 0; c < NC; c++) begin
            m_rem[c] = 0;
            m_ptr[c] = '0;
        end
    endtask

    task automatic cfg(input logic [AW-1:0] b0, b1, b2, b3, input logic [AW-1:0] n0, n1, n2, n3);
        ch_base_addr = {b3, b2, b1, b0};
        ch_nnz       = {n3, n2, n1, n0};
    endtask

    // Called just after a rising edge with this cycle's inputs already applied.
    task automatic step();
        int unsigned     tot, exp_ch, cnt, c;
        logic            exp_iss, ret;
        logic [AW-1:0]   exp_addr;
        logic [3*DW-1:0] word;
        logic [NC-1:0]   exp_stall, exp_done;
        tot = 0; exp_iss = 1'b0; exp_ch = 0;
        for (int unsigned i = 0; i < NC; i++) tot += m_rem[i];
        if (m_state == M_RUN) begin
            for (int unsigned k = 1; k <= NC; k++) begin
                c = (m_rr + k) % NC;
                if (!exp_iss && m_rem[c] != 0 && !ch_hold[c]) begin
                    exp_iss = 1'b1;
                    exp_ch  = c;
                end
            end
        end
        exp_addr = exp_iss ? m_ptr[exp_ch] : '0;
        ret  = (fl.size() > 0) && (fl[0].due == cyc);
        word = ret ? (use_fixed ? fixed_word : mem_word(fl[0].addr)) : {$urandom, $urandom, $urandom};
        mem_rd_data = word;
        exp_stall = '1;
        if (ret) exp_stall[fl[0].ch] = 1'b0;
        for (int unsigned i = 0; i < NC; i++) begin
            cnt = 0;
            foreach (fl[j]) if (fl[j].ch == i) cnt++;
            exp_done[i] = (m_state != M_IDLE) && (m_rem[i] == 0) && (cnt == 0);
        end
        #1;
        chk("rd_en", mem_rd_en, exp_iss);
        chk("rd_addr", mem_rd_addr, exp_addr);
        chk("stall", spm_fetch_stall, exp_stall);
        chk("done", spm_fetch_done, exp_done);
        chk("busy", busy, (m_state == M_RUN) || (m_state == M_DRAIN));
        chk("all_done", all_done, m_state == M_DONE);
        chk("val", spm_val, ret ? word[DW-1:0] : '0);
        chk("col_idx", spm_col_idx, ret ? word[2*DW-1:DW] : '0);
        chk("row_len", spm_row_len, ret ? word[3*DW-1:2*DW] : '0);
        if (mem_rd_en === 1'b1) begin
            iss_log.push_back(mem_rd_addr);
            iss_cyc.push_back(cyc);
        end
        if (spm_fetch_stall !== '1) ret_log.push_back({spm_fetch_stall, spm_val, spm_col_idx, spm_row_len});
        if (ret) void'(fl.pop_front());
        if (spmv_init) begin
            model_reset();
        end else begin
            case (m_state)
                M_IDLE, M_DONE: if (start) begin
                    for (int unsigned i = 0; i < NC; i++) begin
                        m_ptr[i] = ch_base_addr[i*AW +: AW];
                        m_rem[i] = ch_nnz[i*AW +: AW];
                    end
                    m_state = M_RUN;
                end
                M_RUN: if (tot == 0) m_state = M_DRAIN;
                       else if (exp_iss) begin
                           fl.push_back('{cyc + ML, exp_ch, m_ptr[exp_ch]});
                           m_ptr[exp_ch] = m_ptr[exp_ch] + 1'b1;
                           m_rem[exp_ch]--;
                           m_rr = exp_ch;
                       end
                M_DRAIN: if (fl.size() == 0) m_state = M_DONE;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic init_step();
        spmv_init = 1'b1;
        step();
        spmv_init = 1'b0;
    endtask

    initial begin
        int n;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_rd_en", mem_rd_en, 1'b0);
        chk("rst_rd_addr", mem_rd_addr, '0);
        chk("rst_stall", spm_fetch_stall, 4'b1111);
        chk("rst_done", spm_fetch_done, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_all_done", all_done, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc++;

        // Mixed nnz including an empty channel.
        cfg(16'h10, 16'h20, 16'h30, 16'h40, 2, 1, 0, 3);
        iss_log.delete(); iss_cyc.delete();
        start = 1'b1; step(); start = 1'b0;
        chk("t1_done2_first_run", spm_fetch_done[2], 1'b1);
        n = 0;
        while (all_done !== 1'b1 && n < 40) begin step(); n++; end
        chk("t1_all_done", all_done, 1'b1);
        chk("t1_issue_count", iss_log.size(), 6);
        for (int i = 0; i < 6 && i < iss_log.size(); i++) chk("t1_issue_addr", iss_log[i], exp_t1[i]);
        if (iss_cyc.size() == 6) begin
            chk("t1_consecutive", iss_cyc[5] - iss_cyc[0], 5);
            chk("t1_done_latency", cyc - iss_cyc[5], 3);
        end

        // Held channel is skipped, then served once released.
        init_step();
        cfg(16'h100, 16'h200, 16'h300, 16'h400, 2, 2, 2, 2);
        iss_log.delete(); iss_cyc.delete();
        ch_hold = 4'b0010;
        start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        ch_hold = 4'b0000;
        n = 0;
        while (all_done !== 1'b1 && n < 40) begin step(); n++; end
        chk("t2_issue_count", iss_log.size(), 8);
        for (int i = 0; i < 8 && i < iss_log.size(); i++) chk("t2_issue_order", iss_log[i], exp_t2[i]);
        if (iss_cyc.size() == 8) chk("t2_rd_en_continuous", iss_cyc[7] - iss_cyc[0], 7);

        // Single return to channel 2 with fixed fields.
        init_step();
        cfg(16'h10, 16'h20, 16'h30, 16'h40, 0, 0, 1, 0);
        use_fixed = 1'b1;
        fixed_word = {32'd5, 32'd7, 32'h3F800000};
        ret_log.delete();
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (all_done !== 1'b1 && n < 40) begin step(); n++; end
        use_fixed = 1'b0;
        chk("t3_return_count", ret_log.size(), 1);
        if (ret_log.size() > 0) chk("t3_return_word", ret_log[0], {4'b1011, 32'h3F800000, 32'd7, 32'd5});

        // spmv_init with two reads in flight drops both returns.
        init_step();
        cfg(16'h500, 16'h600, 16'h700, 16'h800, 4, 0, 0, 0);
        start = 1'b1; step(); start = 1'b0;
        step();
        ret_log.delete();
        init_step();
        chk("t4_busy", busy, 1'b0);
        chk("t4_done", spm_fetch_done, 4'b0000);
        chk("t4_stall", spm_fetch_stall, 4'b1111);
        repeat (3) step();
        chk("t4_late_returns", ret_log.size(), 0);

        // Asynchronous reset pulse between edges during RUN, then a clean rerun.
        cfg(16'h900, 16'hA00, 16'hB00, 16'hC00, 3, 3, 3, 3);
        start = 1'b1; step(); start = 1'b0;
        step();
        chk("t5_pre_rd_en", mem_rd_en, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_rd_en", mem_rd_en, 1'b0);
        chk("t5_rst_stall", spm_fetch_stall, 4'b1111);
        chk("t5_rst_busy", busy, 1'b0);
        model_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b1; step(); start = 1'b0;
        n = 0;
        while (all_done !== 1'b1 && n < 60) begin step(); n++; end
        chk("t5_rerun_all_done", all_done, 1'b1);

        // All channels empty: RUN, DRAIN, DONE with no reads.
        init_step();
        cfg(16'h1, 16'h2, 16'h3, 16'h4, 0, 0, 0, 0);
        iss_log.delete(); iss_cyc.delete();
        start = 1'b1; step(); start = 1'b0;
        chk("t6_run_busy", busy, 1'b1);
        chk("t6_run_done_all", spm_fetch_done, 4'b1111);
        step();
        chk("t6_drain_busy", busy, 1'b1);
        chk("t6_drain_all_done", all_done, 1'b0);
        step();
        chk("t6_done", all_done, 1'b1);
        chk("t6_no_reads", iss_log.size(), 0);

        // Randomized passes, restarting from DONE and occasionally from IDLE.
        for (int p = 0; p < 20; p++) begin
            logic [AW-1:0] b [NC];
            logic [AW-1:0] k [NC];
            if (p % 4 == 0) init_step();
            for (int c = 0; c < NC; c++) begin
                b[c] = (p % 5 == 0) ? AW'(16'hFFFD + c) : AW'($urandom);
                k[c] = AW'($urandom_range(0, 5));
            end
            cfg(b[0], b[1], b[2], b[3], k[0], k[1], k[2], k[3]);
            start = 1'b1; step(); start = 1'b0;
            n = 0;
            while (m_state != M_DONE && n < 200) begin
                ch_hold = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
                start = ($urandom_range(0, 7) == 0);
                step();
                n++;
            end
            ch_hold = '0;
            start = 1'b0;
            chk("rand_all_done", all_done, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
